// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stages: occupancy states,
// default ID/EX widths and control-field bit positions.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam int ID_EX_CTRL_W = 14;
    localparam int ID_EX_DATA_W = 175;

    // ID/EX control field layout, LSB first
    localparam int CTRL_REG_WRITE_BIT  = 0;
    localparam int CTRL_MEM_WRITE_BIT  = 1;
    localparam int CTRL_ALU_CTRL_LSB   = 2;
    localparam int CTRL_ALU_CTRL_W     = 5;
    localparam int CTRL_BRANCH_BIT     = 7;
    localparam int CTRL_JUMP_BIT       = 8;
    localparam int CTRL_ALU_SRC_BIT    = 9;
    localparam int CTRL_RESULT_SRC_LSB = 10;
    localparam int CTRL_RESULT_SRC_W   = 3;
    localparam int CTRL_LUI_BIT        = 13;

endpackage

// File: rtl/pipe_stage_skid.sv
// Elastic valid/ready pipeline stage with flush and an optional two-entry
// skid buffer that keeps in_ready registered without losing throughput.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int CTRL_W = ID_EX_CTRL_W,
    parameter int DATA_W = ID_EX_DATA_W,
    parameter bit SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    state_t state, state_nxt;

    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_data, skid_data;

    logic accept, emit;
    logic load_main_in, load_main_skid, load_skid;

    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt    = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        state_nxt = TWO;
                        load_skid = 1'b1;
                    end else if (emit) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only the drain can happen
                    if (emit) begin
                        state_nxt      = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= EMPTY;
            main_ctrl <= '0;
            main_data <= '0;
        end else begin
            state <= state_nxt;
            if (load_main_in) begin
                main_ctrl <= in_ctrl;
                main_data <= in_data;
            end else if (load_main_skid) begin
                main_ctrl <= skid_ctrl;
                main_data <= skid_data;
            end
        end
    end

    // Gating here keeps bubbles harmless even when main_ctrl still holds stale bits
    assign out_ctrl = out_valid ? main_ctrl : '0;
    assign out_data = main_data;
    assign count    = state;

    generate
        if (SKID) begin : g_skid
            logic ready_q;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    ready_q <= 1'b1;
                end else begin
                    ready_q <= (state_nxt != TWO);
                end
            end

            always_ff @(posedge clk) begin
                if (load_skid) begin
                    skid_ctrl <= in_ctrl;
                    skid_data <= in_data;
                end
            end

            assign in_ready = ready_q;
        end else begin : g_noskid
            logic unused_skid;

            assign skid_ctrl   = '0;
            assign skid_data   = '0;
            assign in_ready    = !out_valid | out_ready;
            assign unused_skid = load_skid;
        end
    endgenerate

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

- Parametrised elastic pipeline stage; successor to the fixed ID/EX register.
- Carries a control field and a data payload between two pipeline stages using valid/ready handshaking, with flush support.
- An optional two-entry skid buffer gives full throughput with a registered `in_ready`.
- Instantiated at every inter-stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) of the next core revision, replacing hard-wired per-stage registers.

## Interface

Parameters:

- `CTRL_W`, 14 — control-field width; zeroed on bubbles (regWrite, memWrite, ALUControl, branch, jump, ALUSrc, resultSrc, lui).
- `DATA_W`, 175 — data-payload width; held on bubbles (RD1, RD2, PC, PCPlus4, extImm, Rs1, Rs2, Rd).
- `SKID`, 1 — 1: two-entry skid buffer with registered `in_ready`. 0: single entry with combinational `in_ready`.

Ports:

- `clk` in 1 — the single clock; all state changes on its rising edge.
- `rst` in 1 — reset, synchronous and active-low.
- `flush` in 1 — discards all held entries (branch mispredict or exception).
- `in_valid` in 1 — upstream has an entry.
- `in_ready` out 1 — stage can accept an entry.
- `in_ctrl` in `CTRL_W` — upstream control field.
- `in_data` in `DATA_W` — upstream data payload.
- `out_valid` out 1 — the head entry is valid.
- `out_ready` in 1 — downstream consumes the head entry.
- `out_ctrl` out `CTRL_W` — head control field; all-zero whenever `out_valid`=0.
- `out_data` out `DATA_W` — head data payload.
- `count` out 2 — occupancy, 0..2.

## Operation

- Definitions:
  - accept = `in_valid & in_ready`.
  - emit = `out_valid & out_ready`.
- Storage:
  - main entry drives `out_*`.
  - skid entry exists only when SKID=1.
- States: EMPTY (count 0), ONE (count 1), TWO (count 2; SKID=1 only).
- Transitions (evaluated when `rst`=1 and `flush`=0):
  - EMPTY:
    - accept → ONE, main←in.
  - ONE:
    - accept & emit → ONE, main←in.
    - accept & !emit → TWO, skid←in.
    - !accept & emit → EMPTY.
    - neither → hold.
  - TWO:
    - emit → ONE, main←skid.
    - else hold.
    - accept cannot occur (`in_ready`=0).
- `in_ready`:
  - SKID=1: registered, equal to (next state != TWO).
  - SKID=0: `!out_valid | out_ready` (combinational); ONE→ONE on accept & emit is the only full-throughput path.
- `flush`:
  - Next state EMPTY; `out_valid`←0; `out_ctrl`←0; `out_data` holds.
  - A same-cycle accept or emit is discarded; downstream must not act on the flushed head.
  - `in_ready` returns to 1 the following cycle.
- Priority: `rst`=0 > `flush` > handshake.
- Bubble rule:
  - Whenever `out_valid`=0, `out_ctrl` is all-zero.
  - Downstream may use `out_ctrl` without gating by `out_valid`.
- No arithmetic on the payload. `count` is a 2-bit state encoding; no wrap, since it never exceeds 2.

## Timing

- Reset (`rst`=0 at a rising edge):
  - state EMPTY; `out_valid`=0, `out_ctrl`=0, `out_data`=0, `count`=0.
  - `in_ready`=1 after the edge (SKID=1); with SKID=0 it follows its combinational rule.
  - Reset asserted mid-transfer drops both entries; no partial update.
- Latency: 1 cycle. An entry accepted at edge N appears on `out_*` after edge N when it lands in an empty or draining main entry.
- Throughput: 1 entry/cycle with continuous `out_ready`=1, for both SKID values.
- SKID=1 backpressure:
  - `out_ready` falling at edge N lets at most one further entry in (into skid).
  - `in_ready` drops after that edge.
- Stability: while `out_valid`=1 and `out_ready`=0, `out_ctrl` and `out_data` hold constant.

## Structure

- Shared package `pipe_pkg` holds:
  - the state enum (EMPTY/ONE/TWO);
  - default widths `ID_EX_CTRL_W`=14 and `ID_EX_DATA_W`=175;
  - per-stage control-field bit offsets, so the top level packs and unpacks fields by name.
- Single module, no sub-module. The skid entry is a `generate`-guarded register pair selected by SKID.

## Test plan

- Reset: drive `rst`=0 for 2 cycles with `in_valid`=1 and `in_ctrl`=14'h3FFF → afterwards `out_valid`=0, `out_ctrl`=0, `out_data`=0, `count`=0, `in_ready`=1.
- Streaming, SKID=1: `out_ready`=1, `in_valid`=1, `in_data`=1,2,3,4 on consecutive cycles → `out_data`=1,2,3,4 one cycle later each, no gaps, `count`=1 throughout.
- Backpressure, SKID=1:
  - Stimulus: present A,B,C; drop `out_ready` at the cycle A appears; raise it 3 cycles later.
  - Response: head stays A; `count`=2 holding B; `in_ready`=0 holds C off.
  - Release: A, B, C emitted in order.
- Flush while full:
  - Stimulus: `count`=2 with A,B; pulse `flush` while `in_valid`=1 with C.
  - Response: next cycle `out_valid`=0, `out_ctrl`=0, `count`=0; C lost; `in_ready`=1.
- Simultaneous accept/emit in ONE: head A, `out_ready`=1, `in_valid`=1 with D → next cycle head D, `count` stays 1.
- SKID=0 variant:
  - `out_ready`=0 with head A → `in_ready`=0 combinationally.
  - Raising `out_ready` with `in_valid`=1 → `in_ready`=1 the same cycle; the new entry replaces A at the edge.
